// File: rtl/pipelined_adder_pkg.sv
// pipelined_adder_pkg
//   Shared helpers for the pipelined adder: chunk-width derivation, the
//   configuration legality check, the single-bit full adder the chunk
//   adder is built from, and the control half of a pipeline stage
//   register.
//
//   The data half of the stage register depends on WIDTH. A package
//   cannot see module parameters, so that part of the struct is declared
//   inside pipelined_adder. It wraps stage_flags_t.
package pipelined_adder_pkg;

    // Width of the slice of the operands that each pipeline stage resolves.
    function automatic int chunk_width(input int width, input int stages);
        return (stages > 0) ? (width / stages) : width;
    endfunction

    // The operands must split into STAGES equal, non-empty chunks.
    function automatic bit cfg_ok(input int width, input int stages);
        return (stages >= 1) && (width >= stages) && ((width % stages) == 0);
    endfunction

    // Single-bit full adder. Result is {carry_out, sum}.
    function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
        return {(x & y) | (ci & (x ^ y)), x ^ y ^ ci};
    endfunction

    // Control part of a stage register.
    //   valid : slot carries a real operation (bubbles travel with valid=0)
    //   carry : carry out of the highest chunk resolved so far
    //   ovf   : signed overflow, as if the highest chunk resolved so far
    //           were the MSB chunk. Only the last stage's value is the
    //           true overflow of the full-width result.
    typedef struct packed {
        logic valid;
        logic carry;
        logic ovf;
    } stage_flags_t;

endpackage

// File: rtl/pipelined_adder_chunk.sv
// adder_chunk
//   Combinational CW-bit ripple-carry adder built from single-bit full
//   adders. One instance sits in front of each pipeline stage register.
//
//   Ports:
//     a_i, b_i  : CW-bit operand chunks (b_i is already inverted for subtraction)
//     c_i       : carry into bit 0 of the chunk
//     s_o       : CW-bit sum chunk
//     c_o       : carry out of the chunk MSB
//     c_msb_o   : carry into the chunk MSB; c_o ^ c_msb_o is the signed
//                 overflow when this chunk holds the word MSB
module adder_chunk
    import pipelined_adder_pkg::*;
#(
    parameter int CW = 4
) (
    input  logic [CW-1:0] a_i,
    input  logic [CW-1:0] b_i,
    input  logic          c_i,
    output logic [CW-1:0] s_o,
    output logic          c_o,
    output logic          c_msb_o
);

    always_comb begin
        logic [1:0] fa;
        logic       cy;
        fa      = '0;
        cy      = c_i;
        s_o     = '0;
        c_msb_o = 1'b0;
        for (int i = 0; i < CW; i++) begin
            if (i == CW - 1) begin
                c_msb_o = cy;
            end
            fa     = full_add(a_i[i], b_i[i], cy);
            s_o[i] = fa[0];
            cy     = fa[1];
        end
        c_o = cy;
    end

endmodule

// File: rtl/pipelined_adder.sv
// pipelined_adder
//   WIDTH-bit adder/subtractor split into STAGES equal chunks. Each clock
//   resolves one chunk, and the carry is registered between stages. One
//   operation per cycle is sustained. A single global stall freezes the
//   whole pipe while the output is held.
//
//   Ports:
//     clk, rst            : clock (rising edge), asynchronous active-high reset
//     in_valid / in_ready : input handshake; in_ready = !out_valid || out_ready
//     a, b                : WIDTH-bit operands
//     cin                 : carry-in for addition (ignored when sub=1)
//     sub                 : 0 -> a + b + cin, 1 -> a - b (a + ~b + 1)
//     out_valid/out_ready : output handshake
//     sum                 : result modulo 2^WIDTH
//     cout                : carry out of the MSB (for sub: 1 = no borrow)
//     ovf                 : signed two's-complement overflow
//
//   Latency: an operation accepted at edge n is presented after edge
//   n + STAGES - 1.
module pipelined_adder
    import pipelined_adder_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CW = chunk_width(WIDTH, STAGES);

    if (!cfg_ok(WIDTH, STAGES)) begin : g_cfg_check
        $error("pipelined_adder: WIDTH (%0d) must be a positive multiple of STAGES (%0d)",
               WIDTH, STAGES);
    end

    // acc holds the completed sum chunks below the current stage and the
    // untouched operand-A chunks above it. Each stage overwrites its own
    // chunk in place. bop is the effective B (already inverted for sub).
    typedef struct packed {
        stage_flags_t     f;
        logic [WIDTH-1:0] acc;
        logic [WIDTH-1:0] bop;
    } stage_t;

    stage_t st_q [STAGES];
    stage_t st_d [STAGES];
    stage_t cap;
    logic   advance;

    // The whole pipe moves together. The only place a result can wait is
    // the last stage, so the pipe stalls only when that slot is held.
    assign advance  = !st_q[STAGES-1].f.valid || out_ready;
    assign in_ready = advance;

    // Subtraction is folded in at capture: invert B and force carry-in to 1.
    // After this point the stages never see sub.
    always_comb begin
        cap             = '0;
        cap.f.valid     = in_valid;
        cap.f.carry     = sub | cin;
        cap.acc         = a;
        cap.bop         = sub ? ~b : b;
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        stage_t        prev;
        stage_t        nxt;
        logic [CW-1:0] s_chunk;
        logic          c_chunk;
        logic          c_msb;

        if (k == 0) begin : g_first
            assign prev = cap;
        end else begin : g_next
            assign prev = st_q[k-1];
        end

        adder_chunk #(
            .CW(CW)
        ) u_chunk (
            .a_i    (prev.acc[k*CW +: CW]),
            .b_i    (prev.bop[k*CW +: CW]),
            .c_i    (prev.f.carry),
            .s_o    (s_chunk),
            .c_o    (c_chunk),
            .c_msb_o(c_msb)
        );

        // Carry-in and carry-out of the MSB differ exactly when both
        // operand MSBs agree and the sum MSB does not. This is the usual
        // signed-overflow condition.
        always_comb begin
            nxt                    = prev;
            nxt.acc[k*CW +: CW]    = s_chunk;
            nxt.f.carry            = c_chunk;
            nxt.f.ovf              = c_chunk ^ c_msb;
        end

        assign st_d[k] = nxt;
    end

    // ---- stage registers: all load together on advance, all hold on stall ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                st_q[k] <= '0;
            end
        end else if (advance) begin
            for (int k = 0; k < STAGES; k++) begin
                st_q[k] <= st_d[k];
            end
        end
    end

    assign out_valid = st_q[STAGES-1].f.valid;
    assign sum       = st_q[STAGES-1].acc;
    assign cout      = st_q[STAGES-1].f.carry;
    assign ovf       = st_q[STAGES-1].f.ovf;

endmodule

// File: tb/tb_pipelined_adder.sv
module tb_pipelined_adder;

    localparam int WIDTH  = 16;
    localparam int STAGES = 4;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    pipelined_adder #(
        .WIDTH (WIDTH),
        .STAGES(STAGES)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .sub      (sub),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum),
        .cout     (cout),
        .ovf      (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected response: {cout, ovf, sum}, accept edge index, latency check enable.
    typedef struct {
        logic [17:0] e;
        int          acc;
        bit          lat;
    } exp_t;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        ci;
        logic        sb;
        logic [17:0] e;
    } vec_t;

    exp_t exp_q[$];
    int   checks    = 0;
    int   errors    = 0;
    int   cyc       = 0;
    int   n_pushed  = 0;
    int   n_popped  = 0;
    int   n_discard = 0;

    // Hand-computed directed vectors: expected = {cout, ovf, sum}.
    vec_t dir_v [10] = '{
        '{16'hFFFF, 16'h0001, 1'b0, 1'b0, {1'b1, 1'b0, 16'h0000}},
        '{16'h7FFF, 16'h0000, 1'b1, 1'b0, {1'b0, 1'b1, 16'h8000}},
        '{16'h8000, 16'h8000, 1'b0, 1'b0, {1'b1, 1'b1, 16'h0000}},
        '{16'h0005, 16'h0007, 1'b1, 1'b1, {1'b0, 1'b0, 16'hFFFE}},
        '{16'h0007, 16'h0005, 1'b1, 1'b1, {1'b1, 1'b0, 16'h0002}},
        '{16'h1234, 16'h4321, 1'b0, 1'b0, {1'b0, 1'b0, 16'h5555}},
        '{16'h00FF, 16'h0001, 1'b0, 1'b0, {1'b0, 1'b0, 16'h0100}},
        '{16'h0FFF, 16'h0000, 1'b1, 1'b0, {1'b0, 1'b0, 16'h1000}},
        '{16'h8000, 16'h0001, 1'b1, 1'b1, {1'b1, 1'b1, 16'h7FFF}},
        '{16'h0000, 16'h0000, 1'b0, 1'b1, {1'b1, 1'b0, 16'h0000}}
    };

    vec_t stall_v [6] = '{
        '{16'h0001, 16'h0001, 1'b0, 1'b0, {1'b0, 1'b0, 16'h0002}},
        '{16'h0010, 16'h0020, 1'b0, 1'b0, {1'b0, 1'b0, 16'h0030}},
        '{16'h0100, 16'h0200, 1'b0, 1'b0, {1'b0, 1'b0, 16'h0300}},
        '{16'h1000, 16'h2000, 1'b0, 1'b0, {1'b0, 1'b0, 16'h3000}},
        '{16'hFFFF, 16'hFFFF, 1'b0, 1'b0, {1'b1, 1'b0, 16'hFFFE}},
        '{16'h4000, 16'h4000, 1'b0, 1'b0, {1'b0, 1'b1, 16'h8000}}
    };

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check1(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: (a + beff + c0) mod 2^16, carry out, signed overflow.
    function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y,
                                          input logic ci, input logic s);
        logic [15:0] be;
        logic [16:0] r;
        logic        o;
        be = s ? ~y : y;
        r  = {1'b0, x} + {1'b0, be} + {16'b0, (s | ci)};
        o  = (x[15] == be[15]) && (r[15] != x[15]);
        return {r[16], o, r[15:0]};
    endfunction

    // Called at posedge+#1; returns at posedge+#1 after the accept edge.
    task automatic issue(input logic [15:0] ia, input logic [15:0] ib, input logic ici,
                         input logic isb, input logic [17:0] e, input bit lat);
        int   tries;
        exp_t x;
        tries    = 0;
        a        = ia;
        b        = ib;
        cin      = ici;
        sub      = isb;
        in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            tries++;
            if (tries > 50) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout: in_ready stayed 0, expected 1 within 50 cycles");
                in_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        x.e   = e;
        x.acc = cyc + 1;
        x.lat = lat;
        exp_q.push_back(x);
        n_pushed++;
        @(posedge clk);
        #1;
    endtask

    // Monitor: pop and compare on every output handshake.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got sum=0x%0h with nothing outstanding, expected no output", sum);
            end else begin
                e = exp_q.pop_front();
                n_popped++;
                check1("result{cout,ovf,sum}", {14'b0, cout, ovf, sum}, {14'b0, e.e});
                if (e.lat) check1("latency", cyc - e.acc, STAGES - 1);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected finish before 200us");
        $fatal(1, "watchdog");
    end

    initial begin
        bit stale;
        int w;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        sub       = 1'b0;

        // Reset state, checked during reset.
        #1;
        check1("rst_out_valid", out_valid, 0);
        check1("rst_sum", sum, 0);
        check1("rst_cout", cout, 0);
        check1("rst_ovf", ovf, 0);
        check1("rst_in_ready", in_ready, 1);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check1("post_rst_in_ready", in_ready, 1);

        // Directed vectors, back to back.
        foreach (dir_v[i]) issue(dir_v[i].a, dir_v[i].b, dir_v[i].ci, dir_v[i].sb, dir_v[i].e, 1'b1);
        in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;

        // 20 back-to-back random ops.
        for (int i = 0; i < 20; i++) begin
            logic [15:0] ra;
            logic [15:0] rb;
            logic        rc;
            logic        rs;
            ra = 16'($urandom);
            rb = 16'($urandom);
            rc = 1'($urandom_range(0, 1));
            rs = 1'($urandom_range(0, 1));
            issue(ra, rb, rc, rs, model(ra, rb, rc, rs), 1'b1);
        end
        in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;

        // Six ops with a 3-cycle output stall once results start appearing.
        fork
            begin
                foreach (stall_v[i]) issue(stall_v[i].a, stall_v[i].b, stall_v[i].ci, stall_v[i].sb, stall_v[i].e, 1'b0);
                in_valid = 1'b0;
            end
            begin
                int wv;
                wv = 0;
                while (!out_valid && wv < 50) begin
                    @(posedge clk);
                    #1;
                    wv++;
                end
                check1("stall_out_valid_seen", out_valid, 1);
                out_ready = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    @(negedge clk);
                    check1("stall_in_ready", in_ready, 0);
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        repeat (8) @(posedge clk);
        #1;

        // Reset with three ops in flight.
        issue(16'h1111, 16'h1111, 1'b0, 1'b0, {1'b0, 1'b0, 16'h2222}, 1'b1);
        issue(16'h2222, 16'h2222, 1'b0, 1'b0, {1'b0, 1'b0, 16'h4444}, 1'b1);
        issue(16'hFFFF, 16'h0002, 1'b0, 1'b0, {1'b1, 1'b0, 16'h0001}, 1'b1);
        in_valid = 1'b0;
        rst      = 1'b1;
        #1;
        check1("midrst_out_valid", out_valid, 0);
        check1("midrst_sum", sum, 0);
        check1("midrst_in_ready", in_ready, 1);
        n_discard += exp_q.size();
        exp_q.delete();
        @(posedge clk);
        #1;
        rst   = 1'b0;
        stale = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (out_valid) stale = 1'b1;
        end
        check1("no_stale_after_rst", stale, 0);
        @(posedge clk);
        #1;
        issue(16'h00FF, 16'h0F01, 1'b0, 1'b0, {1'b0, 1'b0, 16'h1000}, 1'b1);
        in_valid = 1'b0;

        // Drain and account for every result.
        w = 0;
        while (exp_q.size() != 0 && w < 100) begin
            @(posedge clk);
            w++;
        end
        repeat (6) @(posedge clk);
        #1;
        check1("drain_empty", exp_q.size(), 0);
        check1("result_count", n_popped, n_pushed - n_discard);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
